// File: rtl/ct_rtu_preg_alloc_96_pkg.sv
// ct_rtu_preg_alloc_96_pkg: shared RTU free-list sizes and a popcount helper.
package ct_rtu_preg_alloc_96_pkg;
  localparam int ENTRY_NUM = 96;
  localparam int PREG_W = 7;
  localparam int ARCH_NUM_DEF = 32;
  function automatic logic [PREG_W-1:0] popcnt(input logic [ENTRY_NUM-1:0] v);
    popcnt = '0;
    for (int i = 0; i < ENTRY_NUM; i++) popcnt += PREG_W'(v[i]);
  endfunction
endpackage

// File: rtl/ct_rtu_encode_96.sv
// ct_rtu_encode_96: 96-bit one-hot to 7-bit binary index (zero for an all-zero input).
module ct_rtu_encode_96
  import ct_rtu_preg_alloc_96_pkg::*;
(
  input  logic [ENTRY_NUM-1:0] x_num_expand,
  output logic [PREG_W-1:0]    x_num
);
  always_comb begin
    x_num = '0;
    for (int i = 0; i < ENTRY_NUM; i++) x_num |= x_num_expand[i] ? PREG_W'(i) : '0;
  end
endmodule

// File: rtl/ct_rtu_preg_alloc_96.sv
// ct_rtu_preg_alloc_96: physical-register free list that pre-selects the lowest free entry
// one cycle ahead; the presented entry is held out of free_q so it cannot be issued twice.
module ct_rtu_preg_alloc_96
  import ct_rtu_preg_alloc_96_pkg::*;
#(
  parameter int ARCH_NUM = ARCH_NUM_DEF
) (
  input  logic                 cpuclk,
  input  logic                 cpurst_b,
  input  logic                 alloc_req,
  input  logic [ENTRY_NUM-1:0] release_expand,
  input  logic                 flush_vld,
  input  logic [ENTRY_NUM-1:0] flush_free_expand,
  output logic                 alloc_vld,
  output logic [ENTRY_NUM-1:0] alloc_expand,
  output logic [PREG_W-1:0]    alloc_preg,
  output logic [PREG_W-1:0]    free_cnt,
  output logic                 err_dbl_free
);
  logic [ENTRY_NUM-1:0] free_q, alloc_expand_q, pool, pick, rest;
  logic [PREG_W-1:0] free_cnt_q;
  logic alloc_vld_q, err_q, fire, err_d;
  assign fire = alloc_req & alloc_vld_q;
  // An unconsumed presented entry goes back into the pool; a flush drops it.
  assign pool = flush_vld ? (flush_free_expand | release_expand)
                          : (free_q | release_expand | (fire ? '0 : alloc_expand_q));
  assign pick = pool & (~pool + ENTRY_NUM'(1));
  assign rest = pool & ~pick;
  assign err_d = err_q | (~flush_vld & |(release_expand & (free_q | alloc_expand_q)));
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      free_q         <= {ENTRY_NUM{1'b1}} << ARCH_NUM;
      alloc_expand_q <= '0;
      alloc_vld_q    <= 1'b0;
      free_cnt_q     <= '0;
      err_q          <= 1'b0;
    end else begin
      free_q         <= rest;
      alloc_expand_q <= pick;
      alloc_vld_q    <= |pool;
      free_cnt_q     <= popcnt(rest);
      err_q          <= err_d;
    end
  end
  ct_rtu_encode_96 u_encode (
    .x_num_expand(alloc_expand_q),
    .x_num       (alloc_preg)
  );
  assign alloc_vld    = alloc_vld_q;
  assign alloc_expand = alloc_expand_q;
  assign free_cnt     = free_cnt_q;
  assign err_dbl_free = err_q;
endmodule

// File: tb/tb_ct_rtu_preg_alloc_96.sv
// tb_ct_rtu_preg_alloc_96: directed vectors plus hand-written allocation, flush and reset sequences.
module tb_ct_rtu_preg_alloc_96;
  logic cpuclk = 1'b0, cpurst_b = 1'b0, alloc_req = 1'b0, flush_vld = 1'b0;
  logic [95:0] release_expand = '0, flush_free_expand = '0, alloc_expand;
  logic alloc_vld, err_dbl_free;
  logic [6:0] alloc_preg, free_cnt;
  int errors = 0, checks = 0;

  typedef struct {
    logic req; logic [95:0] rel; logic flush; logic [95:0] ff;
    logic vld; int preg; int cnt; logic err;
  } vec_t;
  vec_t tv[16];

  ct_rtu_preg_alloc_96 dut (
    .cpuclk(cpuclk), .cpurst_b(cpurst_b), .alloc_req(alloc_req),
    .release_expand(release_expand), .flush_vld(flush_vld),
    .flush_free_expand(flush_free_expand), .alloc_vld(alloc_vld),
    .alloc_expand(alloc_expand), .alloc_preg(alloc_preg),
    .free_cnt(free_cnt), .err_dbl_free(err_dbl_free)
  );

  always #5 cpuclk = ~cpuclk;

  function automatic logic [95:0] bits(input int lo, input int hi);
    logic [95:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input int preg, input int cnt, input logic err);
    logic [95:0] oh = '0;
    if (vld) oh[preg] = 1'b1;
    chk({tag, " vld"}, 96'(alloc_vld), 96'(vld));
    chk({tag, " preg"}, 96'(alloc_preg), 96'(preg));
    chk({tag, " expand"}, alloc_expand, oh);
    chk({tag, " cnt"}, 96'(free_cnt), 96'(cnt));
    chk({tag, " err"}, 96'(err_dbl_free), 96'(err));
  endtask

  task automatic apply(input int k);
    alloc_req = tv[k].req; release_expand = tv[k].rel;
    flush_vld = tv[k].flush; flush_free_expand = tv[k].ff;
    @(posedge cpuclk); #1;
    chk_out($sformatf("vec%0d", k), tv[k].vld, tv[k].preg, tv[k].cnt, tv[k].err);
    alloc_req = 1'b0; release_expand = '0; flush_vld = 1'b0; flush_free_expand = '0;
  endtask

  task automatic step(input logic req);
    alloc_req = req;
    @(posedge cpuclk); #1;
    alloc_req = 1'b0;
  endtask

  initial begin
    // From empty: releases, presented-entry double free, request while empty, full flush
    tv[0]  = '{1'b0, bits(7,7) | bits(40,40), 1'b0, '0, 1'b1, 7, 1, 1'b0};
    tv[1]  = '{1'b1, '0, 1'b0, '0, 1'b1, 40, 0, 1'b0};
    tv[2]  = '{1'b1, '0, 1'b0, '0, 1'b0, 0, 0, 1'b0};
    tv[3]  = '{1'b0, bits(60,60), 1'b0, '0, 1'b1, 60, 0, 1'b0};
    tv[4]  = '{1'b0, bits(60,60), 1'b0, '0, 1'b1, 60, 0, 1'b1};
    tv[5]  = '{1'b1, '0, 1'b0, '0, 1'b0, 0, 0, 1'b1};
    tv[6]  = '{1'b1, '0, 1'b0, '0, 1'b0, 0, 0, 1'b1};
    tv[7]  = '{1'b0, '0, 1'b1, bits(0,95), 1'b1, 0, 95, 1'b1};
    // After reset: flush drops presented 33, flush-cycle overlap is not an error, free_q double free
    tv[8]  = '{1'b1, '0, 1'b0, '0, 1'b1, 33, 62, 1'b0};
    tv[9]  = '{1'b1, bits(52,52), 1'b1, bits(50,95), 1'b1, 50, 45, 1'b0};
    tv[10] = '{1'b1, '0, 1'b0, '0, 1'b1, 51, 44, 1'b0};
    tv[11] = '{1'b0, bits(60,60), 1'b0, '0, 1'b1, 51, 44, 1'b1};
    tv[12] = '{1'b1, '0, 1'b0, '0, 1'b1, 52, 43, 1'b1};
    tv[13] = '{1'b0, bits(33,33), 1'b0, '0, 1'b1, 33, 44, 1'b1};
    tv[14] = '{1'b0, '0, 1'b1, bits(0,95), 1'b1, 0, 95, 1'b1};
    tv[15] = '{1'b1, '0, 1'b0, '0, 1'b1, 1, 94, 1'b1};

    #2 chk_out("reset", 1'b0, 0, 0, 1'b0);
    @(posedge cpuclk); #1 cpurst_b = 1'b1;
    step(1'b0);
    chk_out("first", 1'b1, 32, 63, 1'b0);
    for (int i = 0; i < 64; i++) begin
      chk_out($sformatf("drain%0d", i), 1'b1, 32 + i, 63 - i, 1'b0);
      step(1'b1);
    end
    chk_out("empty", 1'b0, 0, 0, 1'b0);
    step(1'b1);
    chk_out("empty_req", 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 8; k++) apply(k);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      chk_out($sformatf("alloc%0d", i), 1'b1, i, 95 - i, 1'b1);
    end
    alloc_req = 1'b1;
    #2 cpurst_b = 1'b0;
    #1 chk_out("async_rst", 1'b0, 0, 0, 1'b0);
    alloc_req = 1'b0;
    @(posedge cpuclk); #1;
    chk_out("rst_hold", 1'b0, 0, 0, 1'b0);
    cpurst_b = 1'b1;
    step(1'b0);
    chk_out("post_rst", 1'b1, 32, 63, 1'b0);
    for (int k = 8; k < 16; k++) apply(k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
